id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS core; sits directly upstream of the EX-stage ALU.
- Latches decoded operands and control from ID, applies EX/MEM and MEM/WB forwarding, and forms ALU inputs A, B and ALUctr.
- Generates the load-use stall request for the hazard unit.

Parameters:
- WIDTH, 32, datapath width.
- REGW, 5, register-index width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- hold  input  1  freeze EX contents (global pipeline freeze).
- flush  input  1  load a bubble into EX.
- id_rs_data  input  WIDTH  rs read value.
- id_rt_data  input  WIDTH  rt read value.
- id_rs  input  REGW  rs index.
- id_rt  input  REGW  rt index.
- id_dst  input  REGW  destination index (rd/rt/31, already chosen).
- id_imm  input  WIDTH  extended immediate.
- id_shamt  input  5  shamt field.
- id_aluctr  input  4  ALU op code (0000 addu … 1011 lui).
- id_use_imm  input  1  B := imm.
- id_shift  input  1  shift instruction.
- id_shift_var  input  1  shift amount from rs (sllv/srlv/srav).
- id_regwrite  input  1  register write.
- id_memread  input  1  load.
- id_memwrite  input  1  store.
- mem_regwrite  input  1  EX/MEM forwarding write enable.
- mem_dst  input  REGW  EX/MEM forwarding destination.
- mem_result  input  WIDTH  EX/MEM forwarding value.
- wb_regwrite  input  1  MEM/WB forwarding write enable.
- wb_dst  input  REGW  MEM/WB forwarding destination.
- wb_result  input  WIDTH  MEM/WB forwarding value.
- alu_a  output  WIDTH  ALU operand A.
- alu_b  output  WIDTH  ALU operand B.
- alu_ctr  output  4  ALU op code.
- ex_store_data  output  WIDTH  forwarded rt, for stores.
- ex_dst  output  REGW  registered destination.
- ex_regwrite  output  1  registered register write.
- ex_memread  output  1  registered load.
- ex_memwrite  output  1  registered store.
- ex_valid  output  1  EX holds a real instruction.
- load_use_stall  output  1  hazard request.

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high.
- Update priority each posedge: rst > flush > hold > load.
  - rst or flush: load a bubble. All registered fields are 0: valid, regwrite, memread, memwrite, aluctr=0000, dst, data, imm, shamt, flags.
  - hold without flush: all registers keep their value.
  - Otherwise: capture all id_* inputs; ex_valid=1.
- Reset output values: alu_ctr=0, ex_*=0, ex_valid=0, load_use_stall=0. alu_a=alu_b=0, given that the forwarding inputs are idle.
- Latency: 1 cycle from ID capture to registered outputs. Forwarding and operand muxing are combinational on the registered state plus the current mem_*/wb_* inputs.
- Forwarding, per operand src ∈ {rs, rt}:
  - Use mem_result if mem_regwrite && mem_dst==src && src!=0.
  - Else use wb_result if wb_regwrite && wb_dst==src && src!=0.
  - Else use the latched data.
  - MEM has priority over WB. Register 0 is never forwarded; its value is the latched 0.
- Operand formation. The ALU takes shift amount on A and shifted value on B.
  - id_shift && !id_shift_var: A = zero-extended shamt; B = fwd_rt.
  - id_shift && id_shift_var: A = zero-extended fwd_rs[4:0], upper bits 0; B = fwd_rt.
  - Otherwise: A = fwd_rs; B = id_use_imm ? imm : fwd_rt.
  - ex_store_data = fwd_rt always.
  - alu_ctr = latched aluctr. For lui, imm carries the 16-bit field in [15:0].
- load_use_stall (combinational):
  - Asserts when ex_valid && ex_memread && ex_dst!=0 && (ex_dst==id_rs || ex_dst==id_rt).
  - The hazard unit then holds ID/PC and drives flush. Flush has priority over hold, so the bubble still enters EX.
- Bubble behaviour: a bubble produces addu 0+0 with no write side-effects.

Optional Feature:
- Macro: ID_EX_FWD_EN.
- Defined: forwarding as above.
- Undefined: no forwarding; operands use latched data only. load_use_stall becomes a general RAW stall. It asserts for any nonzero id_rs/id_rt matching ex_dst (if ex_valid && ex_regwrite) or mem_dst (if mem_regwrite). A WB match is excluded because the register file writes before it reads.

Test Plan:
- rst=1 for 2 cycles with id_* nonzero -> all outputs 0, ex_valid=0. Release rst, load addu rs=$1(5) rt=$2(7) -> next cycle alu_a=5, alu_b=7, alu_ctr=0000.
- EX holds rs=$3 with latched 1; mem_dst=3, mem_result=0x10; wb_dst=3, wb_result=0x20 (both regwrite=1) -> alu_a=0x10. Drop mem_regwrite -> alu_a=0x20. Use rs=$0 with mem_dst=0 -> alu_a=0.
- srav, rs=0xFFFFFF24, rt=0x80000000 -> alu_a=0x00000004, alu_b=0x80000000, alu_ctr=1010. sll shamt=31 -> alu_a=31.
- EX holds lw to $4; ID has rt=$4 -> load_use_stall=1. Assert hold and flush together -> next cycle ex_valid=0, ex_regwrite=0.
- hold=1 for 3 cycles with changing id_* -> outputs unchanged. rst during hold -> bubble next cycle.
- ID_EX_FWD_EN undefined: ex_dst=5 with ex_regwrite, id_rs=5 -> load_use_stall=1. The same case with the macro defined and not a load -> 0.

Source files
------------

// File: rtl/id_ex_if.sv
// ID -> EX operand stage bus: decoded ID fields, MEM/WB forwarding taps and EX-side operands.
interface id_ex_if #(parameter int WIDTH = 32, parameter int REGW = 5);
    logic [WIDTH-1:0] id_rs_data;
    logic [WIDTH-1:0] id_rt_data;
    logic [REGW-1:0]  id_rs;
    logic [REGW-1:0]  id_rt;
    logic [REGW-1:0]  id_dst;
    logic [WIDTH-1:0] id_imm;
    logic [4:0]       id_shamt;
    logic [3:0]       id_aluctr;
    logic             id_use_imm;
    logic             id_shift;
    logic             id_shift_var;
    logic             id_regwrite;
    logic             id_memread;
    logic             id_memwrite;
    logic             mem_regwrite;
    logic [REGW-1:0]  mem_dst;
    logic [WIDTH-1:0] mem_result;
    logic             wb_regwrite;
    logic [REGW-1:0]  wb_dst;
    logic [WIDTH-1:0] wb_result;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_ctr;
    logic [WIDTH-1:0] ex_store_data;
    logic [REGW-1:0]  ex_dst;
    logic             ex_regwrite;
    logic             ex_memread;
    logic             ex_memwrite;
    logic             ex_valid;
    logic             load_use_stall;

    modport master (
        output id_rs_data, id_rt_data, id_rs, id_rt, id_dst, id_imm, id_shamt, id_aluctr,
               id_use_imm, id_shift, id_shift_var, id_regwrite, id_memread, id_memwrite,
               mem_regwrite, mem_dst, mem_result, wb_regwrite, wb_dst, wb_result,
        input  alu_a, alu_b, alu_ctr, ex_store_data, ex_dst, ex_regwrite, ex_memread,
               ex_memwrite, ex_valid, load_use_stall
    );

    modport slave (
        input  id_rs_data, id_rt_data, id_rs, id_rt, id_dst, id_imm, id_shamt, id_aluctr,
               id_use_imm, id_shift, id_shift_var, id_regwrite, id_memread, id_memwrite,
               mem_regwrite, mem_dst, mem_result, wb_regwrite, wb_dst, wb_result,
        output alu_a, alu_b, alu_ctr, ex_store_data, ex_dst, ex_regwrite, ex_memread,
               ex_memwrite, ex_valid, load_use_stall
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, ALU operand muxing and stall request.
// Define ID_EX_FWD_EN for MEM/WB forwarding; otherwise no forwarding and a full RAW stall.
module id_ex_operand_stage #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  hold,
    input  logic  flush,
    id_ex_if.slave bus
);

    typedef struct packed {
        logic             valid;
        logic             regwrite;
        logic             memread;
        logic             memwrite;
        logic             use_imm;
        logic             shift;
        logic             shift_var;
        logic [3:0]       aluctr;
        logic [4:0]       shamt;
        logic [REGW-1:0]  dst;
        logic [REGW-1:0]  rs;
        logic [REGW-1:0]  rt;
        logic [WIDTH-1:0] rs_data;
        logic [WIDTH-1:0] rt_data;
        logic [WIDTH-1:0] imm;
    } ex_reg_t;

    ex_reg_t          ex_q, ex_d;
    logic [WIDTH-1:0] fwd_rs, fwd_rt;
    logic             rs_hit, rt_hit;

    // A bubble is all-zero, which the ALU sees as addu 0+0 with no side effects.
    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (!hold) begin
            ex_d.valid     = 1'b1;
            ex_d.regwrite  = bus.id_regwrite;
            ex_d.memread   = bus.id_memread;
            ex_d.memwrite  = bus.id_memwrite;
            ex_d.use_imm   = bus.id_use_imm;
            ex_d.shift     = bus.id_shift;
            ex_d.shift_var = bus.id_shift_var;
            ex_d.aluctr    = bus.id_aluctr;
            ex_d.shamt     = bus.id_shamt;
            ex_d.dst       = bus.id_dst;
            ex_d.rs        = bus.id_rs;
            ex_d.rt        = bus.id_rt;
            ex_d.rs_data   = bus.id_rs_data;
            ex_d.rt_data   = bus.id_rt_data;
            ex_d.imm       = bus.id_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ex_q <= '0;
        else     ex_q <= ex_d;
    end

`ifdef ID_EX_FWD_EN
    // MEM beats WB; $0 is never forwarded so it always reads the latched zero.
    always_comb begin
        fwd_rs = ex_q.rs_data;
        if (bus.mem_regwrite && bus.mem_dst == ex_q.rs && ex_q.rs != '0)
            fwd_rs = bus.mem_result;
        else if (bus.wb_regwrite && bus.wb_dst == ex_q.rs && ex_q.rs != '0)
            fwd_rs = bus.wb_result;
        fwd_rt = ex_q.rt_data;
        if (bus.mem_regwrite && bus.mem_dst == ex_q.rt && ex_q.rt != '0)
            fwd_rt = bus.mem_result;
        else if (bus.wb_regwrite && bus.wb_dst == ex_q.rt && ex_q.rt != '0)
            fwd_rt = bus.wb_result;
    end

    always_comb begin
        rs_hit = ex_q.dst == bus.id_rs;
        rt_hit = ex_q.dst == bus.id_rt;
        bus.load_use_stall = ex_q.valid && ex_q.memread && ex_q.dst != '0 && (rs_hit || rt_hit);
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{bus.mem_result, bus.wb_regwrite, bus.wb_dst, bus.wb_result,
                          ex_q.rs, ex_q.rt};

    always_comb begin
        fwd_rs = ex_q.rs_data;
        fwd_rt = ex_q.rt_data;
    end

    // WB producers need no stall: the register file writes before ID reads it.
    always_comb begin
        rs_hit = bus.id_rs != '0 &&
                 ((ex_q.valid && ex_q.regwrite && ex_q.dst == bus.id_rs) ||
                  (bus.mem_regwrite && bus.mem_dst == bus.id_rs));
        rt_hit = bus.id_rt != '0 &&
                 ((ex_q.valid && ex_q.regwrite && ex_q.dst == bus.id_rt) ||
                  (bus.mem_regwrite && bus.mem_dst == bus.id_rt));
        bus.load_use_stall = rs_hit || rt_hit;
    end
`endif

    // Shifts put the amount on A and the shifted value on B.
    always_comb begin
        bus.alu_a = fwd_rs;
        bus.alu_b = ex_q.use_imm ? ex_q.imm : fwd_rt;
        if (ex_q.shift) begin
            bus.alu_b = fwd_rt;
            if (ex_q.shift_var) bus.alu_a = {{(WIDTH-5){1'b0}}, fwd_rs[4:0]};
            else                bus.alu_a = {{(WIDTH-5){1'b0}}, ex_q.shamt};
        end
        bus.alu_ctr       = ex_q.aluctr;
        bus.ex_store_data = fwd_rt;
        bus.ex_dst        = ex_q.dst;
        bus.ex_regwrite   = ex_q.regwrite;
        bus.ex_memread    = ex_q.memread;
        bus.ex_memwrite   = ex_q.memwrite;
        bus.ex_valid      = ex_q.valid;
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Randomized + directed bench for id_ex_operand_stage against an instruction-level reference model.
module tb_id_ex_operand_stage;
    logic clk = 1'b0;
    logic rst, hold, flush;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    id_ex_if #(.WIDTH(32), .REGW(5)) bus ();
    id_ex_operand_stage #(.WIDTH(32), .REGW(5)) dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush), .bus(bus.slave)
    );

    typedef struct {
        bit        valid, regwrite, memread, memwrite, use_imm, shift, shift_var;
        int        aluctr, shamt, dst, rs, rt;
        bit [31:0] rs_data, rt_data, imm;
    } inst_t;

    inst_t m;
    inst_t bubble;

    initial bubble = '{valid: 0, regwrite: 0, memread: 0, memwrite: 0, use_imm: 0, shift: 0,
                       shift_var: 0, aluctr: 0, shamt: 0, dst: 0, rs: 0, rt: 0,
                       rs_data: 0, rt_data: 0, imm: 0};

    // Reference: which instruction sits in EX after each clock edge.
    always @(posedge clk) begin
        if (rst || flush) m = bubble;
        else if (!hold) begin
            m.valid = 1; m.regwrite = bus.id_regwrite; m.memread = bus.id_memread;
            m.memwrite = bus.id_memwrite; m.use_imm = bus.id_use_imm; m.shift = bus.id_shift;
            m.shift_var = bus.id_shift_var; m.aluctr = bus.id_aluctr; m.shamt = bus.id_shamt;
            m.dst = bus.id_dst; m.rs = bus.id_rs; m.rt = bus.id_rt;
            m.rs_data = bus.id_rs_data; m.rt_data = bus.id_rt_data; m.imm = bus.id_imm;
        end
    end

    function automatic bit [31:0] value_of(int src, bit [31:0] latched);
`ifdef ID_EX_FWD_EN
        if (src != 0 && bus.mem_regwrite && bus.mem_dst == src) return bus.mem_result;
        if (src != 0 && bus.wb_regwrite && bus.wb_dst == src) return bus.wb_result;
`endif
        return latched;
    endfunction

    function automatic bit exp_stall();
`ifdef ID_EX_FWD_EN
        return m.valid && m.memread && m.dst != 0 && (m.dst == bus.id_rs || m.dst == bus.id_rt);
`else
        bit hit = 0;
        int srcs[2];
        srcs[0] = bus.id_rs; srcs[1] = bus.id_rt;
        foreach (srcs[i])
            if (srcs[i] != 0 && ((m.valid && m.regwrite && m.dst == srcs[i]) ||
                                 (bus.mem_regwrite && bus.mem_dst == srcs[i]))) hit = 1;
        return hit;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic settle_check();
        bit [31:0] a, b, rsv, rtv;
        #1;
        rsv = value_of(m.rs, m.rs_data);
        rtv = value_of(m.rt, m.rt_data);
        if (m.shift) begin
            a = m.shift_var ? (rsv % 32) : m.shamt;
            b = rtv;
        end else begin
            a = rsv;
            b = m.use_imm ? m.imm : rtv;
        end
        chk("alu_a", bus.alu_a, a);
        chk("alu_b", bus.alu_b, b);
        chk("alu_ctr", bus.alu_ctr, m.aluctr);
        chk("store_data", bus.ex_store_data, rtv);
        chk("ex_dst", bus.ex_dst, m.dst);
        chk("ex_regwrite", bus.ex_regwrite, m.regwrite);
        chk("ex_memread", bus.ex_memread, m.memread);
        chk("ex_memwrite", bus.ex_memwrite, m.memwrite);
        chk("ex_valid", bus.ex_valid, m.valid);
        chk("stall", bus.load_use_stall, exp_stall());
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_id();
        bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_dst = 0;
        bus.id_imm = 0; bus.id_shamt = 0; bus.id_aluctr = 0; bus.id_use_imm = 0;
        bus.id_shift = 0; bus.id_shift_var = 0; bus.id_regwrite = 0; bus.id_memread = 0;
        bus.id_memwrite = 0;
    endtask

    task automatic clear_fwd();
        bus.mem_regwrite = 0; bus.mem_dst = 0; bus.mem_result = 0;
        bus.wb_regwrite = 0; bus.wb_dst = 0; bus.wb_result = 0;
    endtask

    task automatic rand_id();
        bus.id_rs_data = $urandom; bus.id_rt_data = $urandom; bus.id_imm = $urandom;
        bus.id_rs = 5'($urandom_range(0, 7)); bus.id_rt = 5'($urandom_range(0, 7));
        bus.id_dst = 5'($urandom_range(0, 7)); bus.id_shamt = 5'($urandom);
        bus.id_aluctr = 4'($urandom_range(0, 11)); bus.id_use_imm = 1'($urandom);
        bus.id_shift = 1'($urandom); bus.id_shift_var = 1'($urandom);
        bus.id_regwrite = 1'($urandom); bus.id_memread = 1'($urandom);
        bus.id_memwrite = 1'($urandom);
    endtask

    initial begin
        rst = 1; hold = 0; flush = 0;
        clear_id(); clear_fwd();
        tick();
        // Reset with busy ID inputs
        rand_id(); bus.id_rs = 5'd9; bus.id_regwrite = 1;
        for (int i = 0; i < 2; i++) begin
            settle_check();
            chk("rst_valid", bus.ex_valid, 0);
            chk("rst_a", bus.alu_a, 0);
            tick();
        end
        rst = 0;
        clear_id();
        bus.id_rs = 1; bus.id_rs_data = 5; bus.id_rt = 2; bus.id_rt_data = 7;
        bus.id_dst = 3; bus.id_regwrite = 1;
        settle_check(); tick();
        clear_id();
        settle_check();
        chk("addu_a", bus.alu_a, 5); chk("addu_b", bus.alu_b, 7); chk("addu_ctr", bus.alu_ctr, 0);
        tick();

        // Forwarding priority, held in EX
        bus.id_rs = 3; bus.id_rs_data = 1; bus.id_dst = 8; bus.id_regwrite = 1;
        settle_check(); tick();
        hold = 1;
        bus.mem_regwrite = 1; bus.mem_dst = 3; bus.mem_result = 32'h10;
        bus.wb_regwrite = 1; bus.wb_dst = 3; bus.wb_result = 32'h20;
        settle_check();
`ifdef ID_EX_FWD_EN
        chk("fwd_mem", bus.alu_a, 32'h10);
`else
        chk("fwd_off_mem", bus.alu_a, 1);
`endif
        tick();
        bus.mem_regwrite = 0;
        settle_check();
`ifdef ID_EX_FWD_EN
        chk("fwd_wb", bus.alu_a, 32'h20);
`else
        chk("fwd_off_wb", bus.alu_a, 1);
`endif
        tick();
        hold = 0; clear_id();
        settle_check(); tick();
        bus.mem_regwrite = 1; bus.mem_dst = 0; bus.wb_dst = 0;
        settle_check(); chk("fwd_r0", bus.alu_a, 0);
        tick();
        clear_fwd();

        // srav then sll shamt=31
        bus.id_shift = 1; bus.id_shift_var = 1; bus.id_aluctr = 4'b1010;
        bus.id_rs = 6; bus.id_rs_data = 32'hFFFFFF24; bus.id_rt = 7; bus.id_rt_data = 32'h80000000;
        settle_check(); tick();
        bus.id_shift_var = 0; bus.id_shamt = 31; bus.id_aluctr = 4'b0100;
        settle_check();
        chk("srav_a", bus.alu_a, 4); chk("srav_b", bus.alu_b, 32'h80000000);
        chk("srav_ctr", bus.alu_ctr, 4'b1010);
        tick();
        clear_id();
        settle_check(); chk("sll_a", bus.alu_a, 31);

        // Load-use: lw $4 in EX, ID reads $4
        bus.id_memread = 1; bus.id_regwrite = 1; bus.id_dst = 4;
        tick();
        clear_id(); bus.id_rt = 4;
        settle_check(); chk("lu_stall", bus.load_use_stall, 1);
        hold = 1; flush = 1;
        tick();
        hold = 0; flush = 0;
        settle_check();
        chk("lu_bubble_valid", bus.ex_valid, 0); chk("lu_bubble_rw", bus.ex_regwrite, 0);
        tick();

        // Hold for 3 cycles, then reset during hold
        clear_id(); bus.id_rs = 2; bus.id_rs_data = 32'h1234; bus.id_dst = 6; bus.id_regwrite = 1;
        tick();
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            rand_id(); settle_check();
            chk("hold_a", bus.alu_a, 32'h1234);
            tick();
        end
        rst = 1; tick();
        rst = 0; hold = 0; clear_id();
        settle_check(); chk("rst_in_hold", bus.ex_valid, 0);
        tick();

        // Non-load producer in EX, consumer in ID
        bus.id_dst = 5; bus.id_regwrite = 1;
        tick();
        clear_id(); bus.id_rs = 5;
        settle_check();
`ifdef ID_EX_FWD_EN
        chk("raw_nonload", bus.load_use_stall, 0);
`else
        chk("raw_nonload", bus.load_use_stall, 1);
`endif
        tick();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 9) == 0);
            hold  = ($urandom_range(0, 6) == 0);
            rand_id();
            bus.mem_regwrite = 1'($urandom); bus.mem_dst = 5'($urandom_range(0, 7));
            bus.mem_result = $urandom;
            bus.wb_regwrite = 1'($urandom); bus.wb_dst = 5'($urandom_range(0, 7));
            bus.wb_result = $urandom;
            settle_check();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
